// File: rtl/sha256_pkg.sv
// Shared definitions for the bit-serial SHA-256 datapath.
//  SHA_W_WORD  : bits per serial word
//  SHA_ROUNDS  : compression words per block
//  seq_state_t : sequencer FSM states
//  clog2_min1  : $clog2 clamped to at least 1, for counters that may hold a single value
package sha256_pkg;

    localparam int unsigned SHA_W_WORD = 32;
    localparam int unsigned SHA_ROUNDS = 64;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_FLUSH,
        SEQ_DONE
    } seq_state_t;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/bclk_divider.sv
// Bit-clock divider: produces bclk with HALF_PERIOD clk cycles per phase, starting low.
// Ports:
//  clk        in   system clock
//  rst        in   synchronous active-high reset
//  en         in   run enable; 0 forces bclk low and clears the phase counter
//  bclk       out  registered bit clock
//  bit_rise   out  registered strobe, high in the first cycle of each high phase
//  bit_fall   out  registered strobe, high in the first cycle of each low phase after a high
//  fall_tick  out  combinational: bclk falls on the coming edge
module bclk_divider
    import sha256_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bclk,
    output logic bit_rise,
    output logic bit_fall,
    output logic fall_tick
);

    localparam int unsigned PW = $clog2(HALF_PERIOD + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PERIOD - 1);

    logic [PW-1:0] phase;
    logic          phase_end;

    assign phase_end = (phase == PHASE_LAST);
    // Lets the sequencer update counter/round on the same edge that bclk drops.
    assign fall_tick = en && bclk && phase_end;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            phase    <= '0;
            bclk     <= 1'b0;
            bit_rise <= 1'b0;
            bit_fall <= 1'b0;
        end else begin
            bit_rise <= 1'b0;
            bit_fall <= 1'b0;
            if (phase_end) begin
                phase    <= '0;
                bclk     <= ~bclk;
                bit_rise <= ~bclk;
                bit_fall <= bclk;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha_bit_sequencer.sv
// Timing master for the bit-serial SHA-256 datapath. On start, runs ROUNDS words then
// FLUSH_WORDS drain words of W_WORD bits each, then pulses done for one cycle.
// Ports:
//  clk        in   system clock
//  rst        in   synchronous active-high reset
//  start      in   request one block run; ignored while busy
//  busy       out  run in progress (RUN or FLUSH)
//  done       out  one-cycle pulse after the final bit
//  flush      out  high during drain words
//  bclk       out  bit clock; consumers record on rise, play on fall
//  counter    out  bit index within the current word, changes only as bclk falls
//  round      out  word index 0..ROUNDS-1, holds ROUNDS-1 while flushing
//  bit_rise   out  first cycle of each bclk high phase
//  bit_fall   out  first cycle of each bclk low phase following a high
//  word_last  out  counter at its last bit while busy
module sha_bit_sequencer
    import sha256_pkg::*;
#(
    parameter int unsigned W_WORD      = SHA_W_WORD,
    parameter int unsigned ROUNDS      = SHA_ROUNDS,
    parameter int unsigned FLUSH_WORDS = 1,
    parameter int unsigned HALF_PERIOD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      flush,
    output logic                      bclk,
    output logic [$clog2(W_WORD)-1:0] counter,
    output logic [$clog2(ROUNDS)-1:0] round,
    output logic                      bit_rise,
    output logic                      bit_fall,
    output logic                      word_last
);

    localparam int unsigned CW = $clog2(W_WORD);
    localparam int unsigned RW = $clog2(ROUNDS);
    localparam int unsigned FW = clog2_min1(FLUSH_WORDS);

    localparam logic [CW-1:0] CNT_LAST = CW'(W_WORD - 1);
    localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'((FLUSH_WORDS > 0) ? FLUSH_WORDS - 1 : 0);

    seq_state_t    state;
    logic [FW-1:0] flush_cnt;
    logic          fall_tick;

    assign word_last = busy && (counter == CNT_LAST);

    // busy is registered, so the divider starts its first low phase in the first busy cycle.
    bclk_divider #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .en       (busy),
        .bclk     (bclk),
        .bit_rise (bit_rise),
        .bit_fall (bit_fall),
        .fall_tick(fall_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEQ_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            flush     <= 1'b0;
            counter   <= '0;
            round     <= '0;
            flush_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (start) begin
                        state <= SEQ_RUN;
                        busy  <= 1'b1;
                    end
                end
                SEQ_RUN: begin
                    if (fall_tick) begin
                        if (counter == CNT_LAST) begin
                            counter <= '0;
                            if (round == RND_LAST) begin
                                if (FLUSH_WORDS == 0) begin
                                    state <= SEQ_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    round <= '0;
                                end else begin
                                    state     <= SEQ_FLUSH;
                                    flush     <= 1'b1;
                                    flush_cnt <= '0;
                                end
                            end else begin
                                round <= round + 1'b1;
                            end
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                end
                SEQ_FLUSH: begin
                    if (fall_tick) begin
                        if (counter == CNT_LAST) begin
                            counter <= '0;
                            if (flush_cnt == FL_LAST) begin
                                state <= SEQ_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                flush <= 1'b0;
                                round <= '0;
                            end else begin
                                flush_cnt <= flush_cnt + 1'b1;
                            end
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                end
                SEQ_DONE: begin
                    if (start) begin
                        state <= SEQ_RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= SEQ_IDLE;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_bit_sequencer.sv
// Directed bench for sha_bit_sequencer: default configuration plus a small
// HALF_PERIOD=1, ROUNDS=4, FLUSH_WORDS=0 instance.
module tb_sha_bit_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy, done, flush, bclk, bit_rise, bit_fall, word_last;
    logic [4:0] counter;
    logic [5:0] round;

    logic       start2;
    logic       busy2, done2, flush2, bclk2, bit_rise2, bit_fall2, word_last2;
    logic [4:0] counter2;
    logic [1:0] round2;

    int tests = 0;
    int fails = 0;
    int cyc;
    int nbusy;
    int nflush;
    int inj_cyc;
    bit injected;
    bit got_done;

    sha_bit_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .flush    (flush),
        .bclk     (bclk),
        .counter  (counter),
        .round    (round),
        .bit_rise (bit_rise),
        .bit_fall (bit_fall),
        .word_last(word_last)
    );

    sha_bit_sequencer #(
        .W_WORD     (32),
        .ROUNDS     (4),
        .FLUSH_WORDS(0),
        .HALF_PERIOD(1)
    ) dut2 (
        .clk      (clk),
        .rst      (rst),
        .start    (start2),
        .busy     (busy2),
        .done     (done2),
        .flush    (flush2),
        .bclk     (bclk2),
        .counter  (counter2),
        .round    (round2),
        .bit_rise (bit_rise2),
        .bit_fall (bit_fall2),
        .word_last(word_last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample 1 time unit after the rising edge; inputs are also driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset with start held high
        rst    = 1'b1;
        start  = 1'b1;
        start2 = 1'b0;
        repeat (3) begin
            tick();
            chk("t1_busy_in_rst", 32'(busy), 0);
        end
        chk("t1_done", 32'(done), 0);
        chk("t1_flush", 32'(flush), 0);
        chk("t1_bclk", 32'(bclk), 0);
        chk("t1_counter", 32'(counter), 0);
        chk("t1_round", 32'(round), 0);
        chk("t1_bit_rise", 32'(bit_rise), 0);
        chk("t1_bit_fall", 32'(bit_fall), 0);
        chk("t1_word_last", 32'(word_last), 0);
        chk("t1_busy2", 32'(busy2), 0);
        chk("t1_bclk2", 32'(bclk2), 0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_bclk", 32'(bclk), 0);

        // 2/3/4: full default run, start sampled at edge 0; stray start mid-round 5
        start    = 1'b1;
        injected = 1'b0;
        inj_cyc  = -10;
        nbusy    = 0;
        nflush   = 0;
        got_done = 1'b0;
        cyc      = 1;
        while (cyc <= 9000) begin
            tick();
            if (cyc == 1 || cyc == inj_cyc + 1) start = 1'b0;
            if (busy) nbusy++;
            if (flush) begin
                nflush++;
                chk("t3_round_in_flush", 32'(round), 63);
            end
            chk("strobe_exclusive", 32'(bit_rise & bit_fall), 0);
            if (cyc == 1) begin
                chk("t2_busy_c1", 32'(busy), 1);
                chk("t2_bclk_c1", 32'(bclk), 0);
                chk("t2_counter_c1", 32'(counter), 0);
                chk("t2_round_c1", 32'(round), 0);
            end
            if (cyc == 3) chk("t2_bclk_c3", 32'(bclk), 1);
            if (cyc >= 3 && cyc <= 127 && (cyc - 3) % 4 == 0) begin
                chk("t2_rise_strobe", 32'(bit_rise), 1);
                chk("t2_counter_at_rise", 32'(counter), 32'((cyc - 3) / 4));
            end
            if (cyc == 128) begin
                chk("t2_word_last_c128", 32'(word_last), 1);
                chk("t2_counter_c128", 32'(counter), 31);
                chk("t2_round_c128", 32'(round), 0);
            end
            if (cyc == 129) begin
                chk("t2_counter_wrap", 32'(counter), 0);
                chk("t2_round_step", 32'(round), 1);
                chk("t2_fall_strobe", 32'(bit_fall), 1);
                chk("t2_bclk_c129", 32'(bclk), 0);
            end
            if (!injected && round == 6'd5 && counter == 5'd10) begin
                start    = 1'b1;
                injected = 1'b1;
                inj_cyc  = cyc;
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
            cyc++;
        end
        chk("t3_done_seen", 32'(got_done), 1);
        chk("t4_injected", 32'(injected), 1);
        chk("t3_done_cycle", 32'(cyc), 8321);
        chk("t3_busy_cycles", 32'(nbusy), 8320);
        chk("t3_flush_cycles", 32'(nflush), 128);
        chk("t3_done_busy", 32'(busy), 0);
        chk("t3_done_bclk", 32'(bclk), 0);
        chk("t3_done_counter", 32'(counter), 0);
        chk("t3_done_round", 32'(round), 0);
        chk("t3_done_flush", 32'(flush), 0);

        // start in the DONE cycle restarts immediately
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_restart_busy", 32'(busy), 1);
        chk("t4_restart_done", 32'(done), 0);
        chk("t4_restart_round", 32'(round), 0);
        chk("t4_restart_counter", 32'(counter), 0);
        chk("t4_restart_bclk", 32'(bclk), 0);

        // 5: reset at round 10, counter 17
        cyc = 0;
        while (!(round == 6'd10 && counter == 5'd17) && cyc < 60000) begin
            tick();
            cyc++;
        end
        chk("t5_reached_point", 32'(round == 6'd10 && counter == 5'd17), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_bclk", 32'(bclk), 0);
        chk("t5_counter", 32'(counter), 0);
        chk("t5_round", 32'(round), 0);
        chk("t5_flush", 32'(flush), 0);
        chk("t5_bit_rise", 32'(bit_rise), 0);
        got_done = 1'b0;
        repeat (20) begin
            tick();
            if (done || busy) got_done = 1'b1;
        end
        chk("t5_no_done_after_abort", 32'(got_done), 0);

        start = 1'b1;
        tick();
        start    = 1'b0;
        nbusy    = 0;
        got_done = 1'b0;
        cyc      = 0;
        while (cyc < 9000) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) nbusy++;
            tick();
            cyc++;
        end
        chk("t5_rerun_done", 32'(got_done), 1);
        chk("t5_rerun_busy_cycles", 32'(nbusy), 8320);

        // 6: HALF_PERIOD=1, ROUNDS=4, FLUSH_WORDS=0
        start2 = 1'b1;
        tick();
        start2   = 1'b0;
        nbusy    = 0;
        got_done = 1'b0;
        cyc      = 1;
        while (cyc <= 400) begin
            if (done2) begin
                got_done = 1'b1;
                break;
            end
            if (busy2) begin
                nbusy++;
                chk("t6_bclk", 32'(bclk2), 32'(cyc % 2 == 0));
                chk("t6_bit_rise", 32'(bit_rise2), 32'(cyc % 2 == 0));
            end
            if (cyc == 256) begin
                chk("t6_last_round", 32'(round2), 3);
                chk("t6_last_counter", 32'(counter2), 31);
                chk("t6_no_flush", 32'(flush2), 0);
            end
            tick();
            cyc++;
        end
        chk("t6_done_seen", 32'(got_done), 1);
        chk("t6_done_cycle", 32'(cyc), 257);
        chk("t6_busy_cycles", 32'(nbusy), 256);
        chk("t6_done_bclk", 32'(bclk2), 0);
        chk("t6_done_round", 32'(round2), 0);
        tick();
        chk("t6_done_pulse_once", 32'(done2), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
